// File: rtl/tt_sum_pkg.sv
// Shared constants and types for the adder-tile result path.
package tt_sum_pkg;

    localparam int SUM_W     = 8;
    localparam int CAP_DEPTH = 4;

    typedef logic [SUM_W-1:0] sum_t;

endpackage

// File: rtl/tt_sum_capture_if.sv
// Valid/ready stream carrying captured result words to the consumer.
interface tt_sum_capture_if
    import tt_sum_pkg::*;
#(
    parameter int DATA_W = SUM_W
);

    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/tt_sync_fifo.sv
// Small circular-buffer FIFO with occupancy counter and combinational head read.
module tt_sync_fifo
    import tt_sum_pkg::*;
#(
    parameter int DATA_W = SUM_W,
    parameter int DEPTH  = CAP_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;

    logic push_ok;
    logic pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop) && !clear;
    assign pop_ok  = pop && !empty && !clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/tt_sum_capture.sv
// Captures the half-rate adder result bus on strobe falling edges into a FIFO.
// Define TT_SUM_CAPTURE_PARITY_EN to add even-parity checking (par_in / par_err).
module tt_sum_capture
    import tt_sum_pkg::*;
#(
    parameter int DATA_W = SUM_W,
    parameter int DEPTH  = CAP_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    strobe_in,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    clear,
`ifdef TT_SUM_CAPTURE_PARITY_EN
    input  logic                    par_in,
    output logic                    par_err,
`endif
    tt_sum_capture_if.master        m_if,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow
);

    logic strobe_q,   strobe_d;
    logic overflow_q, overflow_d;

    logic cap;
    logic par_ok;
    logic pop;
    logic want_push;
    logic push;
    logic drop;
    logic fifo_full;
    logic fifo_empty;

`ifdef TT_SUM_CAPTURE_PARITY_EN
    logic par_err_q, par_err_d;

    assign par_ok  = ~(^{data_in, par_in});
    assign par_err = par_err_q;

    always_comb begin
        par_err_d = par_err_q;
        if (clear) begin
            par_err_d = 1'b0;
        end else if (cap && !par_ok) begin
            par_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
`else
    assign par_ok = 1'b1;
`endif

    // The producer changes its bus after the strobe rises, so the fall sees stable data.
    assign cap       = strobe_q && !strobe_in;
    assign pop       = m_if.m_valid && m_if.m_ready;
    assign want_push = cap && par_ok;
    assign push      = want_push && (!fifo_full || pop);
    assign drop      = want_push && fifo_full && !pop;

    always_comb begin
        strobe_d   = strobe_in;
        overflow_d = overflow_q;
        if (clear) begin
            overflow_d = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            strobe_q   <= strobe_d;
            overflow_q <= overflow_d;
        end
    end

    tt_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .clear   (clear),
        .wr_data (data_in),
        .rd_data (m_if.m_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign m_if.m_valid = !fifo_empty;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_tt_sum_capture.sv
// Randomized and directed bench for tt_sum_capture against a queue-based reference model.
module tb_tt_sum_capture;
    import tt_sum_pkg::*;

    localparam int DEPTH = CAP_DEPTH;

    logic       clk;
    logic       rst;
    logic       strobe_in;
    sum_t       data_in;
    logic       clear;
    logic       par_in;
    logic [2:0] level;
    logic       overflow;
`ifdef TT_SUM_CAPTURE_PARITY_EN
    logic       par_err;
`endif

    tt_sum_capture_if #(.DATA_W(SUM_W)) m_if ();

    tt_sum_capture #(
        .DATA_W (SUM_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .strobe_in (strobe_in),
        .data_in   (data_in),
        .clear     (clear),
`ifdef TT_SUM_CAPTURE_PARITY_EN
        .par_in    (par_in),
        .par_err   (par_err),
`endif
        .m_if      (m_if.master),
        .level     (level),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Reference model: a plain queue of accepted words plus sticky flags.
    sum_t q_m [$];
    bit   prev_s_m;
    bit   ovf_m;
    bit   perr_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic compare_all();
        check("level", 32'(level), 32'(q_m.size()));
        check("m_valid", 32'(m_if.m_valid), 32'(q_m.size() != 0));
        if (q_m.size() != 0) begin
            check("m_data", 32'(m_if.m_data), 32'(q_m[0]));
        end
        check("overflow", 32'(overflow), 32'(ovf_m));
`ifdef TT_SUM_CAPTURE_PARITY_EN
        check("par_err", 32'(par_err), 32'(perr_m));
`endif
    endtask

    task automatic model_step(input logic s, input sum_t d, input logic rdy,
                              input logic clr, input logic p);
        bit cap;
        bit ok;
        bit pop;
        cap      = prev_s_m && !s;
        prev_s_m = s;
        ok       = 1'b1;
`ifdef TT_SUM_CAPTURE_PARITY_EN
        ok = ((^d) == p);
`endif
        pop = rdy && (q_m.size() != 0);
        if (clr) begin
            q_m.delete();
            ovf_m  = 1'b0;
            perr_m = 1'b0;
        end else begin
            if (pop) void'(q_m.pop_front());
            if (cap) begin
                if (!ok)                    perr_m = 1'b1;
                else if (q_m.size() < DEPTH) q_m.push_back(d);
                else                        ovf_m = 1'b1;
            end
        end
    endtask

    // One clock: check state left by the previous edge, then drive this cycle's inputs.
    task automatic cycle(input logic s, input sum_t d, input logic rdy,
                         input logic clr, input logic p);
        @(negedge clk);
        compare_all();
        strobe_in   = s;
        data_in     = d;
        m_if.m_ready = rdy;
        clear       = clr;
        par_in      = p;
        $display("cyc t=%0t s=%0b d=%02h rdy=%0b clr=%0b p=%0b lvl=%0d", $time, s, d, rdy, clr, p, level);
        model_step(s, d, rdy, clr, p);
    endtask

    function automatic logic good_par(input sum_t d);
        return ^d;
    endfunction

    // Rising then falling strobe; the capture happens on the second cycle.
    task automatic capture(input sum_t d, input logic rdy);
        cycle(1'b1, d, rdy, 1'b0, good_par(d));
        cycle(1'b0, d, rdy, 1'b0, good_par(d));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        strobe_in = 1'b1;
        clear     = 1'b0;
        q_m.delete();
        ovf_m    = 1'b0;
        perr_m   = 1'b0;
        prev_s_m = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_level", 32'(level), 32'd0);
            check("rst_valid", 32'(m_if.m_valid), 32'd0);
        end
        rst = 1'b0;
        $display("reset released t=%0t strobe_in=1", $time);
        model_step(strobe_in, data_in, m_if.m_ready, clear, par_in);
    endtask

    initial begin
        logic s_r;
        sum_t d_r;
        rst          = 1'b1;
        strobe_in    = 1'b1;
        data_in      = '0;
        clear        = 1'b0;
        par_in       = 1'b0;
        m_if.m_ready = 1'b0;

        // Strobe held high across reset release: no capture until it falls.
        do_reset();
        repeat (3) cycle(1'b1, 8'h99, 1'b1, 1'b0, good_par(8'h99));
        check("no_spurious_cap", 32'(level), 32'd0);

        // Basic in-order delivery with a free-running sink.
        capture(8'h05, 1'b1);
        capture(8'h7F, 1'b1);
        capture(8'hFE, 1'b1);
        repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Six captures into a stalled sink: four kept, overflow sticks.
        for (int i = 0; i < 6; i++) capture(sum_t'(8'h10 + i), 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("full_level", 32'(level), 32'd4);
        check("full_ovf", 32'(overflow), 32'd1);
        check("full_head", 32'(m_if.m_data), 32'h10);
        repeat (6) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Full FIFO with push and pop in the same cycle.
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) capture(sum_t'(8'h20 + i), 1'b0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0, good_par(8'hAA));
        cycle(1'b0, 8'hAA, 1'b1, 1'b0, good_par(8'hAA));
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("pushpop_level", 32'(level), 32'd4);
        check("pushpop_ovf", 32'(overflow), 32'd0);
        repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Clear coinciding with a capture, three words queued.
        for (int i = 0; i < 3; i++) capture(sum_t'(8'h30 + i), 1'b0);
        cycle(1'b1, 8'h77, 1'b0, 1'b0, good_par(8'h77));
        cycle(1'b0, 8'h77, 1'b0, 1'b1, good_par(8'h77));
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("clear_level", 32'(level), 32'd0);
        check("clear_valid", 32'(m_if.m_valid), 32'd0);
        check("clear_ovf", 32'(overflow), 32'd0);

`ifdef TT_SUM_CAPTURE_PARITY_EN
        cycle(1'b1, 8'h03, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h03, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("bad_par_err", 32'(par_err), 32'd1);
        check("bad_par_level", 32'(level), 32'd0);
        cycle(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("good_par_data", 32'(m_if.m_data), 32'h03);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
`endif

        // Randomized traffic: mostly clk/2 strobe, random sink stalls, rare clears.
        s_r = strobe_in;
        for (int i = 0; i < 400; i++) begin
            logic p_r;
            if ($urandom_range(0, 4) != 0) s_r = ~s_r;
            d_r = sum_t'($urandom);
            p_r = good_par(d_r);
`ifdef TT_SUM_CAPTURE_PARITY_EN
            if ($urandom_range(0, 7) == 0) p_r = ~p_r;
`endif
            cycle(s_r, d_r, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 40) == 0), p_r);
            if (i == 200) begin
                do_reset();
                s_r = 1'b1;
            end
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
